// File: rtl/ptos_tx_controller_if.sv
// Control bundle between ptos_tx_controller (master) and its word source,
// shift register and two flex counters (slave side).
interface ptos_tx_controller_if #(
  parameter int CNT_BITS = 4
) ();
  logic                data_valid;
  logic                data_ready;
  logic                tx_abort;
  logic                tx_done;
  logic [1:0]          tx_sel;
  logic                load_enable;
  logic                shift_enable;
  logic                timer_clear;
  logic                timer_enable;
  logic [CNT_BITS-1:0] timer_rollover_val;
  logic                timer_rollover_flag;
  logic                bit_clear;
  logic                bit_enable;
  logic [CNT_BITS-1:0] bit_rollover_val;
  logic                bit_rollover_flag;

  modport master (
    input  data_valid, tx_abort, timer_rollover_flag, bit_rollover_flag,
    output data_ready, tx_done, tx_sel, load_enable, shift_enable,
           timer_clear, timer_enable, timer_rollover_val,
           bit_clear, bit_enable, bit_rollover_val
  );

  modport slave (
    output data_valid, tx_abort, timer_rollover_flag, bit_rollover_flag,
    input  data_ready, tx_done, tx_sel, load_enable, shift_enable,
           timer_clear, timer_enable, timer_rollover_val,
           bit_clear, bit_enable, bit_rollover_val
  );
endinterface

// File: rtl/ptos_tx_controller.sv
// Serial-transmit sequencer: frames a parallel word as START | data | [PARITY] | STOP.
// Optional parity bit period is compiled in with `define TX_PARITY_EN.
module ptos_tx_controller #(
  parameter int NUM_BITS     = 8,
  parameter int CNT_BITS     = 4,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  ptos_tx_controller_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic       data_ready_s, tx_done_s, load_s, shift_s;
  logic       t_clear_s, t_en_s, b_clear_s, b_en_s;
  logic [1:0] tx_sel_s;

  // State register; async reset forces IDLE so outputs settle in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and output decode. The timer is enabled in every state that
  // watches the rollover flag, so the flag alone is the bit-period tick there.
  always_comb begin
    state_d      = state_q;
    data_ready_s = 1'b0;
    tx_done_s    = 1'b0;
    tx_sel_s     = 2'd0;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    t_clear_s    = 1'b0;
    t_en_s       = 1'b0;
    b_clear_s    = 1'b1;
    b_en_s       = 1'b0;
    case (state_q)
      IDLE: begin
        data_ready_s = 1'b1;
        t_clear_s    = 1'b1;
        if (bus.data_valid) state_d = LOAD;
        else                state_d = IDLE;
      end
      LOAD: begin
        load_s  = 1'b1;
        t_en_s  = 1'b1;
        state_d = START;
      end
      START: begin
        tx_sel_s = 2'd1;
        t_en_s   = 1'b1;
        if (bus.tx_abort)                 state_d = IDLE;
        else if (bus.timer_rollover_flag) state_d = DATA;
        else                              state_d = START;
      end
      DATA: begin
        tx_sel_s  = 2'd2;
        t_en_s    = 1'b1;
        b_clear_s = 1'b0;
        if (bus.tx_abort) begin
          state_d = IDLE;
        end else if (bus.timer_rollover_flag) begin
          b_en_s = 1'b1;
          // Bit 0 is on the line after load, so the last bit needs no shift.
          if (!bus.bit_rollover_flag) begin
            shift_s = 1'b1;
            state_d = DATA;
          end else begin
`ifdef TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        tx_sel_s = 2'd3;
        t_en_s   = 1'b1;
        if (bus.tx_abort)                 state_d = IDLE;
        else if (bus.timer_rollover_flag) state_d = STOP;
        else                              state_d = PARITY;
      end
`endif
      STOP: begin
        t_en_s = 1'b1;
        if (bus.tx_abort)                 state_d = IDLE;
        else if (bus.timer_rollover_flag) state_d = DONE;
        else                              state_d = STOP;
      end
      DONE: begin
        tx_done_s = 1'b1;
        t_clear_s = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        t_clear_s = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  // Handshake outputs are held low for the whole time reset is asserted.
  assign bus.data_ready         = data_ready_s & ~rst;
  assign bus.tx_done            = tx_done_s & ~rst;
  assign bus.tx_sel             = tx_sel_s;
  assign bus.load_enable        = load_s;
  assign bus.shift_enable       = shift_s;
  assign bus.timer_clear        = t_clear_s;
  assign bus.timer_enable       = t_en_s;
  assign bus.bit_clear          = b_clear_s;
  assign bus.bit_enable         = b_en_s;
  assign bus.timer_rollover_val = CNT_BITS'(CLKS_PER_BIT);
  assign bus.bit_rollover_val   = CNT_BITS'(NUM_BITS - 1);

endmodule

// File: tb/tb_ptos_tx_controller.sv
// Bench for ptos_tx_controller: models both flex counters and scoreboards
// load/shift/done events against cycle numbers derived from the frame format.
module tb_ptos_tx_controller;
  localparam int NUM_BITS = 8;
  localparam int CNT_BITS = 4;
  localparam int C        = 10;
`ifdef TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME   = NUM_BITS + 2 + PAR;
  localparam int K_LOAD  = 0;
  localparam int K_SHIFT = 1;
  localparam int K_DONE  = 2;

  typedef struct { int kind; int cyc; } ev_t;
  ev_t exp_q[$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   tcnt;
  int   bcnt;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] mon_obs;
  ev_t  mon_ev;

  ptos_tx_controller_if #(.CNT_BITS(CNT_BITS)) bus ();

  ptos_tx_controller #(
    .NUM_BITS(NUM_BITS), .CNT_BITS(CNT_BITS), .CLKS_PER_BIT(C)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;

  // Flex counter models: clear to 0, +1 when enabled, rollover_val wraps to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= 0;
      bcnt <= 0;
    end else begin
      if (bus.timer_clear)       tcnt <= 0;
      else if (bus.timer_enable) tcnt <= (tcnt == C) ? 1 : tcnt + 1;
      if (bus.bit_clear)         bcnt <= 0;
      else if (bus.bit_enable)   bcnt <= (bcnt == NUM_BITS - 1) ? 1 : bcnt + 1;
    end
  end
  assign bus.timer_rollover_flag = (tcnt == C);
  assign bus.bit_rollover_flag   = (bcnt == NUM_BITS - 1);

  // Scoreboard: pop one expected event per observed load/shift/done pulse.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_cmp++; n_err++;
        $display("FAIL sb_missing: kind %0d due at cycle %0d not seen (now %0d)",
                 exp_q[0].kind, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      mon_obs = {bus.tx_done, bus.shift_enable, bus.load_enable};
      for (int k = 0; k < 3; k++) begin
        if (mon_obs[k] === 1'b1) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: kind %0d at cycle %0d, none expected", k, cyc);
          end else begin
            mon_ev = exp_q.pop_front();
            if (mon_ev.kind != k || mon_ev.cyc != cyc) begin
              n_err++;
              $display("FAIL sb_event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                       k, cyc, mon_ev.kind, mon_ev.cyc);
            end
          end
        end
      end
    end
  end

  task automatic push_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Accept in cycle a: LOAD a+1, START a+2.., shift on data ticks 1..NUM_BITS-1.
  task automatic push_frame(input int a);
    push_ev(K_LOAD, a + 1);
    for (int k = 1; k < NUM_BITS; k++) push_ev(K_SHIFT, a + 1 + C + k * C);
    push_ev(K_DONE, a + 2 + FRAME * C);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.data_valid = 1'b0;
    bus.tx_abort   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.data_ready, bus.tx_done} !== 2'b00) begin
      n_err++; $display("FAIL rst_handshake: got %b, expected 00", {bus.data_ready, bus.tx_done});
    end
    n_cmp++;
    if (bus.tx_sel !== 2'd0) begin
      n_err++; $display("FAIL rst_tx_sel: got %0d, expected 0", bus.tx_sel);
    end
    n_cmp++;
    if ({bus.load_enable, bus.shift_enable, bus.timer_enable, bus.bit_enable} !== 4'b0000) begin
      n_err++; $display("FAIL rst_enables: got %b, expected 0000",
                        {bus.load_enable, bus.shift_enable, bus.timer_enable, bus.bit_enable});
    end
    n_cmp++;
    if ({bus.timer_clear, bus.bit_clear} !== 2'b11) begin
      n_err++; $display("FAIL rst_clears: got %b, expected 11", {bus.timer_clear, bus.bit_clear});
    end
    n_cmp++;
    if (bus.timer_rollover_val !== 4'd10 || bus.bit_rollover_val !== 4'd7) begin
      n_err++; $display("FAIL rollover_vals: got %0d/%0d, expected 10/7",
                        bus.timer_rollover_val, bus.bit_rollover_val);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.data_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_release_ready: got %b, expected 1", bus.data_ready);
    end
  endtask

  task automatic test_single_frame();
    int a, t_data, t_done, n_low;
    int n_sel[4];
    t_data = -1; t_done = -1; n_low = 0;
    for (int s = 0; s < 4; s++) n_sel[s] = 0;
    @(negedge clk);
    bus.data_valid = 1'b1;
    #1;
    n_cmp++;
    if (bus.data_ready !== 1'b1) begin
      n_err++; $display("FAIL single_ready: got %b, expected 1", bus.data_ready);
    end
    a = cyc;
    push_frame(a);
    @(negedge clk);
    bus.data_valid = 1'b0;
    #1;
    for (int i = 0; i < FRAME * C + 20 && t_done < 0; i++) begin
      if (bus.data_ready === 1'b0) n_low++;
      if (bus.tx_done === 1'b1) begin
        t_done = cyc;
      end else begin
        if (cyc > a + 1) n_sel[bus.tx_sel]++;
        if (bus.tx_sel === 2'd2 && t_data < 0) t_data = cyc;
        @(negedge clk);
        #1;
      end
    end
    n_cmp++;
    if (t_done < 0) begin
      n_err++; $display("FAIL single_timeout: tx_done not seen, expected within %0d cycles", FRAME * C + 20);
    end
    n_cmp++;
    if (n_sel[1] != C || n_sel[2] != NUM_BITS * C || n_sel[3] != PAR * C || n_sel[0] != C) begin
      n_err++; $display("FAIL single_sel_runs: got start/data/par/stop %0d/%0d/%0d/%0d, expected %0d/%0d/%0d/%0d",
                        n_sel[1], n_sel[2], n_sel[3], n_sel[0], C, NUM_BITS * C, PAR * C, C);
    end
    n_cmp++;
    if (n_low != FRAME * C + 2) begin
      n_err++; $display("FAIL single_ready_low: got %0d cycles, expected %0d", n_low, FRAME * C + 2);
    end
    // Counted inclusively: the first DATA cycle is cycle 1.
    n_cmp++;
    if (t_done - t_data + 1 != (FRAME - 1) * C + 1) begin
      n_err++; $display("FAIL single_data_to_done: got %0d, expected %0d",
                        t_done - t_data + 1, (FRAME - 1) * C + 1);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.data_ready !== 1'b1 || exp_q.size() != 0) begin
      n_err++; $display("FAIL single_end: ready %b pending %0d, expected ready 1 pending 0",
                        bus.data_ready, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int a, t_done1, t_load2, n_load, n_done;
    t_done1 = -1; t_load2 = -1; n_load = 0; n_done = 0;
    @(negedge clk);
    bus.data_valid = 1'b1;
    #1;
    a = cyc;
    push_frame(a);
    push_frame(a + 3 + FRAME * C);
    for (int i = 0; i < 2 * FRAME * C + 40 && n_done < 2; i++) begin
      @(negedge clk);
      #1;
      if (bus.load_enable === 1'b1) begin
        n_load++;
        if (n_load == 2) begin
          t_load2 = cyc;
          bus.data_valid = 1'b0;
        end
      end
      if (bus.tx_done === 1'b1) begin
        n_done++;
        if (n_done == 1) t_done1 = cyc;
      end
    end
    bus.data_valid = 1'b0;
    n_cmp++;
    if (n_done != 2 || n_load != 2) begin
      n_err++; $display("FAIL b2b_counts: got %0d loads %0d dones, expected 2 and 2", n_load, n_done);
    end
    n_cmp++;
    if (t_load2 - t_done1 != 2) begin
      n_err++; $display("FAIL b2b_gap: got %0d cycles, expected 2", t_load2 - t_done1);
    end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL b2b_pending: got %0d events left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_valid_ignored();
    int a, p1, p2, t_done;
    t_done = -1;
    @(negedge clk);
    bus.data_valid = 1'b1;
    #1;
    a = cyc;
    push_frame(a);
    p1 = a + 5;
    p2 = a + 2 + (FRAME - 1) * C + 4;
    for (int i = 0; i < FRAME * C + 20 && t_done < 0; i++) begin
      @(negedge clk);
      bus.data_valid = (cyc == p1 || cyc == p2);
      #1;
      if (bus.data_valid) begin
        n_cmp++;
        if (bus.data_ready !== 1'b0) begin
          n_err++; $display("FAIL ign_ready: cycle %0d got %b, expected 0", cyc, bus.data_ready);
        end
      end
      if (bus.tx_done === 1'b1) t_done = cyc;
    end
    bus.data_valid = 1'b0;
    n_cmp++;
    if (t_done != a + 2 + FRAME * C) begin
      n_err++; $display("FAIL ign_done_cycle: got %0d, expected %0d", t_done, a + 2 + FRAME * C);
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL ign_pending: got %0d events left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_abort();
    int a;
    @(negedge clk);
    bus.data_valid = 1'b1;
    #1;
    a = cyc;
    push_ev(K_LOAD, a + 1);
    push_ev(K_SHIFT, a + 1 + 2 * C);
    push_ev(K_SHIFT, a + 1 + 3 * C);
    @(negedge clk);
    bus.data_valid = 1'b0;
    for (int i = 0; i < 200 && cyc < a + 1 + 4 * C; i++) @(negedge clk);
    bus.tx_abort = 1'b1;
    #1;
    n_cmp++;
    if (bus.tx_sel !== 2'd2 || bus.timer_rollover_flag !== 1'b1) begin
      n_err++; $display("FAIL abort_on_tick: got sel %0d flag %b, expected 2 and 1",
                        bus.tx_sel, bus.timer_rollover_flag);
    end
    n_cmp++;
    if ({bus.shift_enable, bus.bit_enable, bus.tx_done} !== 3'b000) begin
      n_err++; $display("FAIL abort_beats_tick: got %b, expected 000",
                        {bus.shift_enable, bus.bit_enable, bus.tx_done});
    end
    @(negedge clk);
    bus.tx_abort = 1'b0;
    #1;
    n_cmp++;
    if (bus.data_ready !== 1'b1 || bus.tx_sel !== 2'd0) begin
      n_err++; $display("FAIL abort_idle: got ready %b sel %0d, expected 1 and 0", bus.data_ready, bus.tx_sel);
    end
    repeat (FRAME * C) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL abort_pending: got %0d events left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_data();
    int a;
    @(negedge clk);
    bus.data_valid = 1'b1;
    #1;
    a = cyc;
    push_frame(a);
    @(negedge clk);
    bus.data_valid = 1'b0;
    for (int i = 0; i < 200 && cyc < a + 30; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.tx_sel !== 2'd2) begin
      n_err++; $display("FAIL midrst_pre: got sel %0d, expected 2", bus.tx_sel);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    n_cmp++;
    if (bus.tx_sel !== 2'd0 || bus.shift_enable !== 1'b0 || bus.data_ready !== 1'b0) begin
      n_err++; $display("FAIL midrst_outputs: got sel %0d shift %b ready %b, expected 0 0 0",
                        bus.tx_sel, bus.shift_enable, bus.data_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.data_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_release: got ready %b, expected 1", bus.data_ready);
    end
  endtask

  initial begin
    bus.data_valid = 1'b0;
    bus.tx_abort   = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_valid_ignored();
    test_abort();
    test_reset_mid_data();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
